// File: rtl/arbitro_pkg.sv
// Shared widths, request-word field offsets and FSM state encoding for the
// memory arbiter.
package arbitro_pkg;
   localparam int ADDR_W  = 24;
   localparam int DATA_W  = 64;
   localparam int PUSH_W  = 1 + ADDR_W + DATA_W;
   localparam int POP_W   = ADDR_W + DATA_W;
   localparam int RW_BIT  = 88;
   localparam int ADDR_HI = 87;
   localparam int ADDR_LO = 64;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      FORWARD   = 2'd3
   } state_e;
endpackage

// File: rtl/reg_pendiente.sv
// One-entry request holding register for one requester, with its Listo
// handshake and sticky overrun flag.
module reg_pendiente
   import arbitro_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              push,
   input  logic [PUSH_W-1:0] d_push,
   input  logic              clr,
   input  logic              busy,
   output logic              valid,
   output logic              listo,
   output logic              overrun,
   output logic [PUSH_W-1:0] word
);
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;
   logic [PUSH_W-1:0] word_q, word_d;

   // busy covers a read of this port still waiting for its response
   assign listo = ~valid_q & ~busy;

   always_comb begin
      valid_d   = valid_q;
      overrun_d = overrun_q;
      word_d    = word_q;
      if (clr) valid_d = 1'b0;
      if (push && listo) begin
         valid_d = 1'b1;
         word_d  = d_push;
      end else if (push) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         word_q    <= '0;
      end else begin
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         word_q    <= word_d;
      end
   end

   assign valid   = valid_q;
   assign overrun = overrun_q;
   assign word    = word_q;
endmodule

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter sharing one downstream Push/Pop memory channel between
// two cache controllers; read responses are routed back to the issuing port.
//
// state     | meaning
// IDLE      | no transaction in flight; grant a pending holding register
// ISSUE     | Push_Mem high for one cycle with the owner's word
// WAIT_RESP | read issued, waiting for PNDNG_Mem (bounded by TIMEOUT)
// FORWARD   | response routed to the owner until it pops
module arbitro_memoria
   import arbitro_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              Push_0,
   input  logic [PUSH_W-1:0] D_Push_0,
   output logic              Listo_0,
   output logic              PNDNG_0,
   output logic [POP_W-1:0]  D_POP_0,
   input  logic              Pop_0,
   input  logic              Push_1,
   input  logic [PUSH_W-1:0] D_Push_1,
   output logic              Listo_1,
   output logic              PNDNG_1,
   output logic [POP_W-1:0]  D_POP_1,
   input  logic              Pop_1,
   output logic              Push_Mem,
   output logic [PUSH_W-1:0] D_Push_Mem,
   input  logic              PNDNG_Mem,
   input  logic [POP_W-1:0]  D_POP_Mem,
   output logic              Pop_Mem,
   output logic [1:0]        Overrun,
   output logic              Timeout_Err
);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              push_mem_q, push_mem_d;
   logic [PUSH_W-1:0] d_push_mem_q, d_push_mem_d;
   logic              t_err_q, t_err_d;

   logic              valid_0, valid_1, clr_0, clr_1, busy_0, busy_1;
   logic [PUSH_W-1:0] word_0, word_1;
   logic              winner, outstanding, fwd_0, fwd_1, pop_mem;

   assign outstanding = (state_q == WAIT_RESP) || (state_q == FORWARD);
   assign busy_0      = outstanding & ~owner_q;
   assign busy_1      = outstanding &  owner_q;

   reg_pendiente u_reg_0 (
      .CLK(CLK), .RST_N(RST_N), .push(Push_0), .d_push(D_Push_0),
      .clr(clr_0), .busy(busy_0), .valid(valid_0), .listo(Listo_0),
      .overrun(Overrun[0]), .word(word_0)
   );

   reg_pendiente u_reg_1 (
      .CLK(CLK), .RST_N(RST_N), .push(Push_1), .d_push(D_Push_1),
      .clr(clr_1), .busy(busy_1), .valid(valid_1), .listo(Listo_1),
      .overrun(Overrun[1]), .word(word_1)
   );

   assign fwd_0   = (state_q == FORWARD) & ~owner_q;
   assign fwd_1   = (state_q == FORWARD) &  owner_q;
   assign PNDNG_0 = fwd_0 & PNDNG_Mem;
   assign PNDNG_1 = fwd_1 & PNDNG_Mem;
   assign D_POP_0 = fwd_0 ? D_POP_Mem : '0;
   assign D_POP_1 = fwd_1 ? D_POP_Mem : '0;
   assign pop_mem = PNDNG_Mem & ((fwd_0 & Pop_0) | (fwd_1 & Pop_1));
   assign Pop_Mem = pop_mem;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      push_mem_d   = 1'b0;
      d_push_mem_d = d_push_mem_q;
      t_err_d      = t_err_q;
      clr_0        = 1'b0;
      clr_1        = 1'b0;
      winner       = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_0 || valid_1) begin
               // on a tie the port that did not win last time goes first
               winner       = (valid_0 && valid_1) ? ~ptr_q : valid_1;
               owner_d      = winner;
               ptr_d        = winner;
               push_mem_d   = 1'b1;
               d_push_mem_d = winner ? word_1 : word_0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            clr_0 = ~owner_q;
            clr_1 =  owner_q;
            if (d_push_mem_q[RW_BIT]) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_RESP;
               cnt_d   = '0;
            end
         end
         WAIT_RESP: begin
            if (PNDNG_Mem) begin
               state_d = FORWARD;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(TIMEOUT)) begin
                  t_err_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         FORWARD: begin
            if (pop_mem) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         ptr_q        <= 1'b1;
         cnt_q        <= '0;
         push_mem_q   <= 1'b0;
         d_push_mem_q <= '0;
         t_err_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         push_mem_q   <= push_mem_d;
         d_push_mem_q <= d_push_mem_d;
         t_err_q      <= t_err_d;
      end
   end

   assign Push_Mem    = push_mem_q;
   assign D_Push_Mem  = d_push_mem_q;
   assign Timeout_Err = t_err_q;
endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: table of uncontested writes plus
// hand-written read, arbitration, overrun/timeout and reset sequences.
module tb_arbitro_memoria;
   import arbitro_pkg::*;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              Push_0 = 1'b0, Push_1 = 1'b0, Pop_0 = 1'b0, Pop_1 = 1'b0;
   logic [PUSH_W-1:0] D_Push_0 = '0, D_Push_1 = '0;
   logic              PNDNG_Mem = 1'b0;
   logic [POP_W-1:0]  D_POP_Mem = '0;
   logic              Listo_0, Listo_1, PNDNG_0, PNDNG_1, Push_Mem, Pop_Mem, Timeout_Err;
   logic [POP_W-1:0]  D_POP_0, D_POP_1;
   logic [PUSH_W-1:0] D_Push_Mem;
   logic [1:0]        Overrun;

   arbitro_memoria #(.TIMEOUT(8)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .Push_0(Push_0), .D_Push_0(D_Push_0), .Listo_0(Listo_0), .PNDNG_0(PNDNG_0),
      .D_POP_0(D_POP_0), .Pop_0(Pop_0),
      .Push_1(Push_1), .D_Push_1(D_Push_1), .Listo_1(Listo_1), .PNDNG_1(PNDNG_1),
      .D_POP_1(D_POP_1), .Pop_1(Pop_1),
      .Push_Mem(Push_Mem), .D_Push_Mem(D_Push_Mem), .PNDNG_Mem(PNDNG_Mem),
      .D_POP_Mem(D_POP_Mem), .Pop_Mem(Pop_Mem), .Overrun(Overrun),
      .Timeout_Err(Timeout_Err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic              port;
      logic [PUSH_W-1:0] word;
      logic [PUSH_W-1:0] exp;
   } vec_t;

   vec_t vecs[4];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic nxt();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      Push_0 = 1'b0; Push_1 = 1'b0; Pop_0 = 1'b0; Pop_1 = 1'b0; PNDNG_Mem = 1'b0;
      nxt(); nxt();
      RST_N = 1'b1;
   endtask

   task automatic push(input logic p, input logic [PUSH_W-1:0] w);
      if (!p) begin Push_0 = 1'b1; D_Push_0 = w; end
      else    begin Push_1 = 1'b1; D_Push_1 = w; end
   endtask

   task automatic unpush();
      Push_0 = 1'b0; Push_1 = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, {1'b1, 24'h00_0010, 64'hDEAD_BEEF_0000_0001},
                  89'h1_00_0010_DEAD_BEEF_0000_0001};
      vecs[1] = '{1'b1, {1'b1, 24'h00_0020, 64'h0000_0000_0000_0002},
                  89'h1_00_0020_0000_0000_0000_0002};
      vecs[2] = '{1'b1, {1'b1, 24'hFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
                  89'h1_FF_FFFF_FFFF_FFFF_FFFF_FFFF};
      vecs[3] = '{1'b0, {1'b1, 24'hA5_5A00, 64'h0123_4567_89AB_CDEF},
                  89'h1_A5_5A00_0123_4567_89AB_CDEF};

      #2;
      chk("rst_listo", {Listo_1, Listo_0}, 2'b11);
      chk("rst_push_mem", {Push_Mem, Pop_Mem, PNDNG_1, PNDNG_0}, 4'b0000);
      chk("rst_d_push_mem", D_Push_Mem, 0);
      chk("rst_flags", {Overrun, Timeout_Err}, 3'b000);
      nxt(); nxt();
      RST_N = 1'b1;

      // uncontested writes: Push_Mem two cycles after the push, Listo back after ISSUE
      for (int i = 0; i < 4; i++) begin
         push(vecs[i].port, vecs[i].word);
         nxt(); unpush();
         chk("wr_listo_busy", vecs[i].port ? Listo_1 : Listo_0, 1'b0);
         chk("wr_no_early_push", Push_Mem, 1'b0);
         nxt();
         chk("wr_push_mem", Push_Mem, 1'b1);
         chk("wr_word", D_Push_Mem, vecs[i].exp);
         nxt();
         chk("wr_push_mem_1cyc", Push_Mem, 1'b0);
         chk("wr_listo_back", vecs[i].port ? Listo_1 : Listo_0, 1'b1);
      end

      // read on port 1 with response five cycles after Push_Mem
      push(1'b1, {1'b0, 24'h00_0040, 64'h0});
      nxt(); unpush();
      nxt();
      chk("rd_push_mem", Push_Mem, 1'b1);
      chk("rd_word", D_Push_Mem, {1'b0, 24'h00_0040, 64'h0});
      repeat (5) nxt();
      chk("rd_listo_wait", Listo_1, 1'b0);
      PNDNG_Mem = 1'b1;
      D_POP_Mem = {24'h00_0040, 64'h1234};
      #1 chk("rd_no_pndng_in_wait", PNDNG_1, 1'b0);
      nxt();
      chk("rd_pndng_1", PNDNG_1, 1'b1);
      chk("rd_d_pop_1", D_POP_1, {24'h00_0040, 64'h1234});
      chk("rd_non_owner", {PNDNG_0, D_POP_0}, 0);
      Pop_0 = 1'b1;
      #1 chk("rd_non_owner_pop", Pop_Mem, 1'b0);
      Pop_0 = 1'b0; Pop_1 = 1'b1;
      #1 chk("rd_pop_mem", Pop_Mem, 1'b1);
      nxt();
      Pop_1 = 1'b0; PNDNG_Mem = 1'b0;
      chk("rd_listo_back", Listo_1, 1'b1);
      chk("rd_pndng_off", PNDNG_1, 1'b0);

      // simultaneous writes after reset: 0 then 1, twice
      do_reset();
      for (int r = 0; r < 2; r++) begin
         push(1'b0, {1'b1, 24'h00_0100, 64'h0000_0000_0000_00A0});
         push(1'b1, {1'b1, 24'h00_0200, 64'h0000_0000_0000_00B1});
         nxt(); unpush();
         nxt();
         chk("arb_first", D_Push_Mem, {1'b1, 24'h00_0100, 64'h0000_0000_0000_00A0});
         chk("arb_first_push", Push_Mem, 1'b1);
         nxt();
         chk("arb_gap", Push_Mem, 1'b0);
         nxt();
         chk("arb_second", D_Push_Mem, {1'b1, 24'h00_0200, 64'h0000_0000_0000_00B1});
         chk("arb_second_push", Push_Mem, 1'b1);
         nxt();
      end

      // port-0 read left unanswered: overrun on re-push, then timeout
      push(1'b0, {1'b0, 24'h00_0300, 64'h0});
      nxt(); unpush();
      nxt();
      chk("to_push_mem", Push_Mem, 1'b1);
      nxt(); nxt();
      chk("to_listo_wait", Listo_0, 1'b0);
      push(1'b0, {1'b1, 24'h00_0BAD, 64'hBAD});
      nxt(); unpush();
      chk("ovr_flag", Overrun, 2'b01);
      chk("ovr_no_push", Push_Mem, 1'b0);
      repeat (5) nxt();
      chk("to_not_yet", Timeout_Err, 1'b0);
      nxt();
      chk("to_err", Timeout_Err, 1'b1);
      chk("to_listo_back", Listo_0, 1'b1);
      nxt();
      chk("ovr_hold_unchanged", Push_Mem, 1'b0);
      push(1'b1, {1'b1, 24'h00_0400, 64'h4});
      nxt(); unpush();
      nxt();
      chk("to_idle_grant", {Push_Mem, D_Push_Mem}, {1'b1, 1'b1, 24'h00_0400, 64'h4});
      nxt();

      // asynchronous reset while forwarding a port-0 response
      push(1'b0, {1'b0, 24'h00_0500, 64'h0});
      nxt(); unpush();
      nxt(); nxt();
      PNDNG_Mem = 1'b1;
      D_POP_Mem = {24'h00_0500, 64'h55};
      nxt();
      chk("fw_pndng_0", PNDNG_0, 1'b1);
      Pop_0 = 1'b1;
      #1 chk("fw_pop_mem", Pop_Mem, 1'b1);
      #1 RST_N = 1'b0;
      #1;
      chk("arst_pop_mem", Pop_Mem, 1'b0);
      chk("arst_pndng", {PNDNG_1, PNDNG_0}, 2'b00);
      chk("arst_d_pop_0", D_POP_0, 0);
      chk("arst_listo", {Listo_1, Listo_0}, 2'b11);
      chk("arst_flags", {Overrun, Timeout_Err}, 3'b000);
      chk("arst_push_mem", {Push_Mem, D_Push_Mem}, 0);
      nxt();
      Pop_0 = 1'b0; PNDNG_Mem = 1'b0;
      RST_N = 1'b1;
      nxt();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Shares one Push/Pop channel to the next memory level between two second-level cache controllers (requester 0, requester 1).
- Buffers one request per requester, picks between them round-robin, and issues the chosen request downstream.
- For reads, waits for the response (PNDNG) and hands it back to the owning requester through its own Push/Pop-style port.
- Sits between the SegundoNivel instances and the memory-side FIFO pair.

Parameters:
- ADDR_W, 24, address field width.
- DATA_W, 64, data field width.
- PUSH_W, 1+ADDR_W+DATA_W (89), request word width.
- POP_W, ADDR_W+DATA_W (88), response word width.
- TIMEOUT, 1023, max cycles in WAIT_RESP before abort; 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Push_0  in  1  request strobe, requester 0 (one-cycle pulse).
- D_Push_0  in  PUSH_W  request word, requester 0.
- Listo_0  out  1  requester 0 may push.
- PNDNG_0  out  1  response available for requester 0.
- D_POP_0  out  POP_W  response word to requester 0.
- Pop_0  in  1  requester 0 consumes the response.
- Push_1, D_Push_1, Listo_1, PNDNG_1, D_POP_1, Pop_1: same as above, for requester 1.
- Push_Mem  out  1  request strobe downstream.
- D_Push_Mem  out  PUSH_W  request word downstream.
- PNDNG_Mem  in  1  downstream response valid.
- D_POP_Mem  in  POP_W  downstream response word.
- Pop_Mem  out  1  consume the downstream response.
- Overrun  out  2  sticky per-port flag: push attempted while Listo=0.
- Timeout_Err  out  1  sticky flag: response timeout.

Behaviour:
- Request word fields: [88] R_W (1 = write/eviction, 0 = read); [87:64] address; [63:0] data.
- Response word fields: [87:64] address; [63:0] data.
- Reset (asynchronous, RST_N=0):
  - FSM goes to IDLE; holding registers are invalid; grant pointer = 1 (requester 0 wins first tie).
  - Timeout counter = 0.
  - Push_Mem=0, D_Push_Mem=0, Pop_Mem=0, PNDNG_x=0, D_POP_x=0, Overrun=0, Timeout_Err=0, Listo_x=1.
  - A transaction in flight is dropped; requesters are reset by the same RST_N.
- Capture:
  - Push_x=1 with Listo_x=1 loads holding register x; it is valid the next cycle.
  - Push_x=1 with Listo_x=0 is ignored and sets Overrun[x].
- Listo_x = holding x empty AND no read owned by x outstanding (WAIT_RESP or FORWARD with owner x).
- FSM states: IDLE, ISSUE, WAIT_RESP, FORWARD.
- IDLE:
  - One holding register valid: grant it.
  - Both valid: grant the port other than the pointer.
  - On grant: latch owner, update pointer := owner, go to ISSUE.
- ISSUE (exactly one cycle):
  - Push_Mem=1 (registered) and D_Push_Mem = the owner's word.
  - Owner's holding register is cleared.
  - R_W=1: go to IDLE. R_W=0: go to WAIT_RESP and clear the timeout counter.
- Latency: an uncontested Push_x at cycle t gives Push_Mem=1 at cycle t+2.
- Back-to-back: the next grant can occur in the IDLE cycle right after an ISSUE of a write.
- WAIT_RESP:
  - PNDNG_Mem=1: go to FORWARD.
  - Counter reaches TIMEOUT (TIMEOUT≠0): set Timeout_Err, go to IDLE; the owner's Listo is restored.
- FORWARD:
  - PNDNG_owner = PNDNG_Mem and D_POP_owner = D_POP_Mem (combinational).
  - Non-owner sees PNDNG=0 and D_POP=0.
  - Pop_Mem = Pop_owner AND PNDNG_Mem (combinational).
  - On Pop_Mem=1, go to IDLE.
  - Pop_x outside FORWARD, or from the non-owner, is ignored.
- Downstream writes get no response. A PNDNG_Mem outside WAIT_RESP/FORWARD is left unpopped.
- Pushes from either port are accepted in any state, subject to Listo.
- Only one downstream transaction is outstanding at a time.

Decomposition:
- Package arbitro_pkg holds:
  - width constants ADDR_W, DATA_W, PUSH_W, POP_W;
  - field offsets RW_BIT=88, ADDR_HI=87, ADDR_LO=64;
  - the 2-bit state enum (IDLE=0, ISSUE=1, WAIT_RESP=2, FORWARD=3).
- Sub-module reg_pendiente, instantiated twice: one-entry holding register with load, clear, valid and the overrun flag.

Test Plan:
- Reset, then Push_0 pulse with D_Push_0 = {1'b1, 24'h00_0010, 64'hDEAD_BEEF_0000_0001} → Push_Mem=1 two cycles later with the same word; Listo_0=1 the cycle after ISSUE; no WAIT_RESP.
- Read on port 1 (R_W=0, addr 24'h00_0040); drive PNDNG_Mem=1 with D_POP_Mem={24'h00_0040, 64'h1234} 5 cycles after Push_Mem → PNDNG_1=1, D_POP_1 matches, PNDNG_0=0; Pop_1 gives Pop_Mem=1 that cycle; Listo_1 returns to 1.
- Push_0 and Push_1 (both writes) in the same cycle after reset → port 0 is issued first, port 1 the next grant; repeating the pair gives 0 then 1 again (pointer alternates).
- Push_0 while a port-0 read is outstanding → Overrun[0]=1, no extra Push_Mem, holding register unchanged.
- Read with TIMEOUT=8 and PNDNG_Mem held 0 → Timeout_Err=1 after 8 WAIT_RESP cycles; FSM in IDLE; Listo_0=1.
- RST_N=0 during FORWARD → all outputs return to reset values asynchronously; Pop_Mem=0 even with Pop_0=1.
